// File: rtl/spi_ram_pkg.sv
// Shared definitions for the serial RAM master and its slave: FSM states,
// frame field widths and mode-bit encodings.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_e;

    localparam int DUMMY_BITS = 1;
    localparam int MODE_BITS  = 1;
    localparam int ADDR_BITS  = 8;
    localparam int DATA_BITS  = 8;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    // Bits before the first data bit of a write; reads add RD_LAT on top.
    localparam int HDR_BITS = DUMMY_BITS + MODE_BITS + ADDR_BITS;

endpackage

// File: rtl/spi_ram_clkgen.sv
// Serial clock generator: divides the system clock by 2*CLK_DIV while enabled
// and marks the cycles on which sclk rises or falls with one-cycle strobes.
module spi_ram_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic rise_stb,
    output logic fall_stb,
    output logic sclk_o
);

    localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

    logic [7:0] phase_q, phase_d;
    logic       sclk_q, sclk_d;
    logic       wrap;

    // NOTE: every output of a combinational block gets a default first; a
    // path that skips an assignment would otherwise infer a latch.
    always_comb begin
        wrap    = en && (phase_q == PHASE_LAST);
        phase_d = 8'd0;
        sclk_d  = 1'b0;
        if (en) begin
            phase_d = wrap ? 8'd0 : phase_q + 8'd1;
            sclk_d  = wrap ? ~sclk_q : sclk_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 8'd0;
            sclk_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            sclk_q  <= sclk_d;
        end
    end

    assign rise_stb = wrap && !sclk_q;
    assign fall_stb = wrap && sclk_q;
    assign sclk_o   = sclk_q;

    always_ff @(posedge clk) begin
        assert (CLK_DIV >= 2 && CLK_DIV <= 255)
            else $error("spi_ram_clkgen: CLK_DIV=%0d outside 2..255", CLK_DIV);
    end

endmodule

// File: rtl/spi_ram_master.sv
// Valid/ready request to serial RAM frame bridge. Define SPI_RAM_MASTER_BURST_EN
// to add req_len and multi-byte frames with slave-side address increment.
module spi_ram_master
    import spi_ram_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int RD_LAT  = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
`ifdef SPI_RAM_MASTER_BURST_EN
    input  logic [7:0] req_len,
`endif
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       cs_o,
    output logic       sclk_o,
    output logic       din_o,
    input  logic       dout_i
);

    localparam int         N_WR      = HDR_BITS + DATA_BITS;
    localparam int         N_RD      = N_WR + RD_LAT;
    localparam int         TX_W      = N_WR + 7;
    localparam logic [4:0] LAST_WR   = 5'(N_WR - 1);
    localparam logic [4:0] LAST_RD   = 5'(N_RD - 1);
    localparam logic [8:0] HOLD_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV - 1);

    state_e            state_q, state_d;
    logic [4:0]        bit_q, bit_d;
    logic [8:0]        tmr_q, tmr_d;
    logic [TX_W-1:0]   tx_q, tx_d;
    logic              wr_q, wr_d;
    logic [7:0]        shadow_q, shadow_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              cs_q, cs_d;
    logic [4:0]        last_bit;
    logic [4:0]        first_data_bit;
    logic              more_bytes;
    logic              rise_stb, fall_stb;

`ifdef SPI_RAM_MASTER_BURST_EN
    logic [7:0] len_q, len_d;
    assign more_bytes = (len_q != 8'd0);
`else
    assign more_bytes = 1'b0;
`endif

    spi_ram_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .en       (state_q == SHIFT),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .sclk_o   (sclk_o)
    );

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        tmr_d       = tmr_q;
        tx_d        = tx_q;
        wr_d        = wr_q;
        shadow_d    = shadow_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
`ifdef SPI_RAM_MASTER_BURST_EN
        len_d       = len_q;
`endif
        last_bit       = (wr_q == MODE_WRITE) ? LAST_WR : LAST_RD;
        first_data_bit = last_bit - 5'd7;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = SHIFT;
                    wr_d    = req_wr;
                    bit_d   = 5'd0;
                    // Read frames carry zeros through the latency and data bits.
                    tx_d    = {1'b0, req_wr, req_addr,
                               (req_wr == MODE_WRITE) ? req_wdata : 8'h00, 7'b0};
`ifdef SPI_RAM_MASTER_BURST_EN
                    len_d   = req_len;
`endif
                end
            end
            SHIFT: begin
`ifdef SPI_RAM_MASTER_BURST_EN
                // Next burst write byte is taken on the response cycle, while sclk is low.
                if (rsp_valid_q && wr_q == MODE_WRITE)
                    tx_d = {req_wdata, {(TX_W - 8){1'b0}}};
`endif
                if (fall_stb) begin
                    tx_d = tx_q << 1;
                    if (wr_q == MODE_READ && bit_q >= first_data_bit)
                        shadow_d = {shadow_q[6:0], dout_i};
                    if (bit_q == last_bit) begin
                        if (more_bytes) begin
                            bit_d       = first_data_bit;
                            rsp_valid_d = 1'b1;
                            if (wr_q == MODE_READ)
                                rdata_d = shadow_d;
`ifdef SPI_RAM_MASTER_BURST_EN
                            len_d       = len_q - 8'd1;
`endif
                        end else begin
                            state_d = HOLD;
                            tmr_d   = 9'd0;
                        end
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end
            end
            HOLD: begin
                if (tmr_q == HOLD_LAST) begin
                    state_d     = GAP;
                    tmr_d       = 9'd0;
                    rsp_valid_d = 1'b1;
                    if (wr_q == MODE_READ)
                        rdata_d = shadow_q;
                end else begin
                    tmr_d = tmr_q + 9'd1;
                end
            end
            GAP: begin
                if (tmr_q == GAP_LAST) begin
                    state_d = IDLE;
                    tmr_d   = 9'd0;
                end else begin
                    tmr_d = tmr_q + 9'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        cs_d = !(state_d == SHIFT || state_d == HOLD);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            bit_q       <= 5'd0;
            tmr_q       <= 9'd0;
            tx_q        <= '0;
            wr_q        <= 1'b0;
            shadow_q    <= 8'h00;
            rdata_q     <= 8'h00;
            rsp_valid_q <= 1'b0;
            cs_q        <= 1'b1;
`ifdef SPI_RAM_MASTER_BURST_EN
            len_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            tmr_q       <= tmr_d;
            tx_q        <= tx_d;
            wr_q        <= wr_d;
            shadow_q    <= shadow_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            cs_q        <= cs_d;
`ifdef SPI_RAM_MASTER_BURST_EN
            len_q       <= len_d;
`endif
        end
    end

    always_ff @(posedge sys_clk) begin
        assert (!(rise_stb && fall_stb))
            else $error("spi_ram_master: sclk rise and fall strobes coincide");
        assert (RD_LAT >= 0 && RD_LAT <= 7)
            else $error("spi_ram_master: RD_LAT=%0d outside 0..7", RD_LAT);
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q == SHIFT) || (state_q == HOLD);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign cs_o      = cs_q;
    assign din_o     = tx_q[TX_W-1];

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed bench for spi_ram_master: serial RAM slave model, response
// scoreboard, and a second fast-clock instance (CLK_DIV=2, RD_LAT=0).
module tb_spi_ram_master;

    localparam int CLK_DIV0 = 4;
    localparam int RD_LAT0  = 2;
    localparam int CLK_DIV1 = 2;
    localparam int RD_LAT1  = 0;

    typedef struct {
        logic       wr;
        logic [7:0] rdata;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    int acc_cyc = 0;
    int rsp_cyc = 0;

    // Instance under test with default timing
    logic       d0_req_valid = 1'b0, d0_req_wr = 1'b0, d0_dout = 1'b0;
    logic [7:0] d0_req_addr = 8'h00, d0_req_wdata = 8'h00, d0_req_len = 8'h00;
    logic       d0_req_ready, d0_rsp_valid, d0_busy, d0_cs_o, d0_sclk_o, d0_din_o;
    logic [7:0] d0_rsp_rdata;

    spi_ram_master #(.CLK_DIV(CLK_DIV0), .RD_LAT(RD_LAT0)) u_dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .req_valid (d0_req_valid),
        .req_ready (d0_req_ready),
        .req_wr    (d0_req_wr),
        .req_addr  (d0_req_addr),
        .req_wdata (d0_req_wdata),
`ifdef SPI_RAM_MASTER_BURST_EN
        .req_len   (d0_req_len),
`endif
        .rsp_valid (d0_rsp_valid),
        .rsp_rdata (d0_rsp_rdata),
        .busy      (d0_busy),
        .cs_o      (d0_cs_o),
        .sclk_o    (d0_sclk_o),
        .din_o     (d0_din_o),
        .dout_i    (d0_dout)
    );

    // Fast instance; its slave always returns ones
    logic       d1_req_valid = 1'b0, d1_req_wr = 1'b0;
    logic [7:0] d1_req_addr = 8'h00, d1_req_wdata = 8'h00, d1_req_len = 8'h00;
    logic       d1_req_ready, d1_rsp_valid, d1_busy, d1_cs_o, d1_sclk_o, d1_din_o;
    logic [7:0] d1_rsp_rdata;

    spi_ram_master #(.CLK_DIV(CLK_DIV1), .RD_LAT(RD_LAT1)) u_fast (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .req_valid (d1_req_valid),
        .req_ready (d1_req_ready),
        .req_wr    (d1_req_wr),
        .req_addr  (d1_req_addr),
        .req_wdata (d1_req_wdata),
`ifdef SPI_RAM_MASTER_BURST_EN
        .req_len   (d1_req_len),
`endif
        .rsp_valid (d1_rsp_valid),
        .rsp_rdata (d1_rsp_rdata),
        .busy      (d1_busy),
        .cs_o      (d1_cs_o),
        .sclk_o    (d1_sclk_o),
        .din_o     (d1_din_o),
        .dout_i    (1'b1)
    );

    // Serial RAM slave: samples din on sclk rise, drives read data on the same rise
    logic [7:0]  mem [256];
    logic [63:0] s_frame = '0;
    int          s_k = 0;
    logic        s_wr = 1'b0;
    logic [7:0]  s_addr = 8'h00;
    logic [7:0]  s_sh = 8'h00;

    always @(posedge d0_sclk_o or negedge d0_cs_o) begin : slave
        int j;
        if (!d0_sclk_o) begin
            s_k     = 0;
            s_frame = '0;
        end else if (!d0_cs_o) begin
            s_frame = {s_frame[62:0], d0_din_o};
            if (s_k == 1) begin
                s_wr = d0_din_o;
            end else if (s_k >= 2 && s_k <= 9) begin
                s_addr = {s_addr[6:0], d0_din_o};
            end else if (s_k >= 10) begin
                if (s_wr) begin
                    j    = (s_k - 10) % 8;
                    s_sh = {s_sh[6:0], d0_din_o};
                    if (j == 7) begin
                        mem[s_addr] = s_sh;
                        s_addr++;
                    end
                end else if (s_k >= 10 + RD_LAT0) begin
                    j       = (s_k - 10 - RD_LAT0) % 8;
                    d0_dout = mem[s_addr][7 - j];
                    if (j == 7) s_addr++;
                end
            end
            s_k++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic wr, input int div, input int rd_lat);
        int n;
        n = wr ? 18 : 18 + rd_lat;
        return 1 + (2 * n + 1) * div;
    endfunction

    // Presents a request at a negedge, waits for acceptance, returns just after the accept edge.
    task automatic send(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                        input bit keep);
        int n = 0;
        d0_req_wr    = wr;
        d0_req_addr  = addr;
        d0_req_wdata = wdata;
        d0_req_valid = 1'b1;
        while (d0_req_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(d0_req_ready), 32'd1);
        acc_cyc = cyc + 1;
        @(posedge clk);
        #1;
        if (!keep) d0_req_valid = 1'b0;
        check("busy_after_accept", 32'(d0_busy), 32'd1);
        check("ready_after_accept", 32'(d0_req_ready), 32'd0);
    endtask

    task automatic wait_rsp();
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (d0_rsp_valid !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("rsp_wait", 32'(d0_rsp_valid), 32'd1);
        rsp_cyc = cyc + 1;
        e = sb.pop_front();
        check("rsp_latency", rsp_cyc - acc_cyc, e.lat);
        if (!e.wr) check("rsp_rdata", 32'(d0_rsp_rdata), 32'(e.rdata));
        check("cs_at_rsp", 32'(d0_cs_o), 32'd1);
        check("busy_at_rsp", 32'(d0_busy), 32'd0);
        @(negedge clk);
        check("rsp_pulse_width", 32'(d0_rsp_valid), 32'd0);
    endtask

    initial begin : main
        int n;
        int pulses;

        repeat (3) @(negedge clk);
        check("rst_cs", 32'(d0_cs_o), 32'd1);
        check("rst_sclk", 32'(d0_sclk_o), 32'd0);
        check("rst_din", 32'(d0_din_o), 32'd0);
        check("rst_ready", 32'(d0_req_ready), 32'd1);
        check("rst_rsp_valid", 32'(d0_rsp_valid), 32'd0);
        check("rst_rdata", 32'(d0_rsp_rdata), 32'd0);
        check("rst_busy", 32'(d0_busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single write: frame bits, slave RAM contents, latency
        sb.push_back('{wr: 1'b1, rdata: 8'h00, lat: exp_lat(1'b1, CLK_DIV0, RD_LAT0)});
        send(1'b1, 8'h5A, 8'hC3, 1'b0);
        wait_rsp();
        check("wr_frame_bits", 32'(s_frame[17:0]), 32'({2'b01, 8'h5A, 8'hC3}));
        check("wr_frame_len", s_k, 32'd18);
        check("wr_mem", 32'(mem[8'h5A]), 32'h0000_00C3);

        // Reset in the middle of a write, sclk high at that point
        send(1'b1, 8'h12, 8'h34, 1'b0);
        while (cyc < acc_cyc + 39) @(negedge clk);
        check("mid_frame_sclk", 32'(d0_sclk_o), 32'd1);
        check("mid_frame_cs", 32'(d0_cs_o), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_cs", 32'(d0_cs_o), 32'd1);
        check("abort_sclk", 32'(d0_sclk_o), 32'd0);
        check("abort_busy", 32'(d0_busy), 32'd0);
        check("abort_ready", 32'(d0_req_ready), 32'd1);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (d0_rsp_valid === 1'b1) pulses++;
        end
        rst_n = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (d0_rsp_valid === 1'b1) pulses++;
        end
        check("abort_no_rsp", pulses, 32'd0);
        check("abort_mem_untouched", 32'(mem[8'h12] === 8'h34), 32'd0);

        // req_valid held across a write then a read of the same address
        sb.push_back('{wr: 1'b1, rdata: 8'h00, lat: exp_lat(1'b1, CLK_DIV0, RD_LAT0)});
        sb.push_back('{wr: 1'b0, rdata: 8'hA5, lat: exp_lat(1'b0, CLK_DIV0, RD_LAT0)});
        send(1'b1, 8'h5A, 8'hA5, 1'b1);
        d0_req_wr    = 1'b0;
        d0_req_wdata = 8'h00;
        wait_rsp();
        n = rsp_cyc;
        send(1'b0, 8'h5A, 8'h00, 1'b0);
        check("back_to_back_gap", acc_cyc - n, 32'(2 * CLK_DIV0));
        wait_rsp();
        check("rd_frame_hdr", 32'(s_frame[19:8]), 32'({2'b00, 8'h5A, 2'b00}));
        check("rd_frame_len", s_k, 32'(18 + RD_LAT0));

        // Fast instance read
        d1_req_wr    = 1'b0;
        d1_req_addr  = 8'h33;
        d1_req_valid = 1'b1;
        n = 0;
        while (d1_req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("fast_accept_wait", 32'(d1_req_ready), 32'd1);
        acc_cyc = cyc + 1;
        sb.push_back('{wr: 1'b0, rdata: 8'hFF, lat: exp_lat(1'b0, CLK_DIV1, RD_LAT1)});
        @(posedge clk);
        #1;
        d1_req_valid = 1'b0;
        n = 0;
        while (d1_rsp_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("fast_rsp_wait", 32'(d1_rsp_valid), 32'd1);
        begin
            exp_t e;
            e = sb.pop_front();
            check("fast_latency", cyc + 1 - acc_cyc, e.lat);
            check("fast_rdata", 32'(d1_rsp_rdata), 32'(e.rdata));
        end

`ifdef SPI_RAM_MASTER_BURST_EN
        // Burst write of four bytes wrapping the address space
        repeat (20) @(negedge clk);
        d0_req_len = 8'd3;
        send(1'b1, 8'hFE, 8'h01, 1'b0);
        pulses = 0;
        for (int b = 0; b < 4; b++) begin
            n = 0;
            @(negedge clk);
            while (d0_rsp_valid !== 1'b1 && n < 400) begin
                @(negedge clk);
                n++;
            end
            check("burst_rsp_wait", 32'(d0_rsp_valid), 32'd1);
            if (d0_rsp_valid === 1'b1) pulses++;
            d0_req_wdata = 8'(b + 2);
        end
        d0_req_len = 8'd0;
        repeat (20) @(negedge clk);
        check("burst_pulses", pulses, 32'd4);
        check("burst_cs_idle", 32'(d0_cs_o), 32'd1);
        check("burst_mem_fe", 32'(mem[8'hFE]), 32'd1);
        check("burst_mem_ff", 32'(mem[8'hFF]), 32'd2);
        check("burst_mem_00", 32'(mem[8'h00]), 32'd3);
        check("burst_mem_01", 32'(mem[8'h01]), 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
